// File: rtl/alu_reservation_station.sv
// ALU-class reservation station: holds decoded ops until both operands are
// resolved by CDB snooping, then issues one ready op per cycle through a registered stage.
module alu_reservation_station #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned OP_W    = 5
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            aluEnable,
    input  logic [(TAG_W-1)+2*(TAG_W+DATA_W)+OP_W-1:0]      aluData,
    input  logic [ADDR_W-1:0]                               inst_PC,
    output logic                                            rsFull,
    input  logic                                            flush,
    input  logic                                            cdbAluValid,
    input  logic [TAG_W-2:0]                                cdbAluTag,
    input  logic [DATA_W-1:0]                               cdbAluData,
    input  logic                                            cdbLsValid,
    input  logic [TAG_W-2:0]                                cdbLsTag,
    input  logic [DATA_W-1:0]                               cdbLsData,
    output logic                                            exValid,
    input  logic                                            exReady,
    output logic [OP_W-1:0]                                 exOp,
    output logic [DATA_W-1:0]                               exA,
    output logic [DATA_W-1:0]                               exB,
    output logic [ADDR_W-1:0]                               exPC,
    output logic [TAG_W-2:0]                                exDest
);
    localparam int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned DEST_W  = TAG_W - 1;
    localparam int unsigned D1_LSB  = OP_W;
    localparam int unsigned T1_LSB  = D1_LSB + DATA_W;
    localparam int unsigned D2_LSB  = T1_LSB + TAG_W;
    localparam int unsigned T2_LSB  = D2_LSB + DATA_W;
    localparam int unsigned DST_LSB = T2_LSB + TAG_W;
    localparam logic [TAG_W-1:0] FREE_TAG = {1'b1, {(TAG_W-1){1'b0}}};

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [OP_W-1:0]    op_q    [ENTRIES];
    logic [OP_W-1:0]    op_d    [ENTRIES];
    logic [DEST_W-1:0]  dest_q  [ENTRIES];
    logic [DEST_W-1:0]  dest_d  [ENTRIES];
    logic [ADDR_W-1:0]  pc_q    [ENTRIES];
    logic [ADDR_W-1:0]  pc_d    [ENTRIES];
    logic [TAG_W-1:0]   tag1_q  [ENTRIES];
    logic [TAG_W-1:0]   tag1_d  [ENTRIES];
    logic [DATA_W-1:0]  data1_q [ENTRIES];
    logic [DATA_W-1:0]  data1_d [ENTRIES];
    logic [TAG_W-1:0]   tag2_q  [ENTRIES];
    logic [TAG_W-1:0]   tag2_d  [ENTRIES];
    logic [DATA_W-1:0]  data2_q [ENTRIES];
    logic [DATA_W-1:0]  data2_d [ENTRIES];

    logic               any_rdy_c;
    logic               issue_c;
    logic [IDX_W-1:0]   sel_c;
    logic [IDX_W-1:0]   free_c;

    // Resolve one pending operand against both CDBs; ALU broadcast wins a tie.
    function automatic void wake(input  logic [TAG_W-1:0]  t_in,
                                 input  logic [DATA_W-1:0] d_in,
                                 output logic [TAG_W-1:0]  t_out,
                                 output logic [DATA_W-1:0] d_out);
        t_out = t_in;
        d_out = d_in;
        if (!t_in[TAG_W-1]) begin
            if (cdbAluValid && (t_in[TAG_W-2:0] == cdbAluTag)) begin
                t_out = FREE_TAG;
                d_out = cdbAluData;
            end else if (cdbLsValid && (t_in[TAG_W-2:0] == cdbLsTag)) begin
                t_out = FREE_TAG;
                d_out = cdbLsData;
            end
        end
    endfunction

    // Next-state: wakeup, select, issue invalidation and allocation.
    always_comb begin
        valid_d   = valid_q;
        any_rdy_c = 1'b0;
        sel_c     = '0;
        free_c    = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            op_d[i]    = op_q[i];
            dest_d[i]  = dest_q[i];
            pc_d[i]    = pc_q[i];
            tag1_d[i]  = tag1_q[i];
            data1_d[i] = data1_q[i];
            tag2_d[i]  = tag2_q[i];
            data2_d[i] = data2_q[i];
            if (valid_q[i]) begin
                wake(tag1_q[i], data1_q[i], tag1_d[i], data1_d[i]);
                wake(tag2_q[i], data2_q[i], tag2_d[i], data2_d[i]);
            end
        end
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (valid_q[i] && tag1_q[i][TAG_W-1] && tag2_q[i][TAG_W-1]) begin
                any_rdy_c = 1'b1;
                sel_c     = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_c = IDX_W'(i);
            end
        end
        issue_c = any_rdy_c && (!exValid || exReady);
        if (issue_c) begin
            valid_d[sel_c] = 1'b0;
        end
        if (aluEnable && !rsFull) begin
            valid_d[free_c] = 1'b1;
            op_d[free_c]    = aluData[OP_W-1:0];
            dest_d[free_c]  = aluData[DST_LSB +: DEST_W];
            pc_d[free_c]    = inst_PC;
            wake(aluData[T1_LSB +: TAG_W], aluData[D1_LSB +: DATA_W], tag1_d[free_c], data1_d[free_c]);
            wake(aluData[T2_LSB +: TAG_W], aluData[D2_LSB +: DATA_W], tag2_d[free_c], data2_d[free_c]);
        end
    end

    // State and issue-stage registers; reset and flush override everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rsFull  <= 1'b0;
            exValid <= 1'b0;
            exOp    <= '0;
            exA     <= '0;
            exB     <= '0;
            exPC    <= '0;
            exDest  <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                op_q[i]    <= '0;
                dest_q[i]  <= '0;
                pc_q[i]    <= '0;
                tag1_q[i]  <= FREE_TAG;
                data1_q[i] <= '0;
                tag2_q[i]  <= FREE_TAG;
                data2_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            rsFull  <= 1'b0;
            exValid <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rsFull  <= &valid_d;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                op_q[i]    <= op_d[i];
                dest_q[i]  <= dest_d[i];
                pc_q[i]    <= pc_d[i];
                tag1_q[i]  <= tag1_d[i];
                data1_q[i] <= data1_d[i];
                tag2_q[i]  <= tag2_d[i];
                data2_q[i] <= data2_d[i];
            end
            if (issue_c) begin
                exValid <= 1'b1;
                exOp    <= op_q[sel_c];
                exA     <= data1_q[sel_c];
                exB     <= data2_q[sel_c];
                exPC    <= pc_q[sel_c];
                exDest  <= dest_q[sel_c];
            end else if (exReady) begin
                exValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: per-cycle vector table plus
// hand-written full/stall, flush and reset sequences.
module tb_alu_reservation_station;
    logic        clk = 1'b0;
    logic        rst;
    logic        aluEnable;
    logic [79:0] aluData;
    logic [31:0] inst_PC;
    logic        rsFull;
    logic        flush;
    logic        cdbAluValid;
    logic [2:0]  cdbAluTag;
    logic [31:0] cdbAluData;
    logic        cdbLsValid;
    logic [2:0]  cdbLsTag;
    logic [31:0] cdbLsData;
    logic        exValid;
    logic        exReady;
    logic [4:0]  exOp;
    logic [31:0] exA;
    logic [31:0] exB;
    logic [31:0] exPC;
    logic [2:0]  exDest;

    int tests = 0;
    int fails = 0;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .aluEnable(aluEnable), .aluData(aluData), .inst_PC(inst_PC),
        .rsFull(rsFull), .flush(flush),
        .cdbAluValid(cdbAluValid), .cdbAluTag(cdbAluTag), .cdbAluData(cdbAluData),
        .cdbLsValid(cdbLsValid), .cdbLsTag(cdbLsTag), .cdbLsData(cdbLsData),
        .exValid(exValid), .exReady(exReady), .exOp(exOp), .exA(exA), .exB(exB),
        .exPC(exPC), .exDest(exDest)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] FT = 4'b1000;

    typedef struct {
        logic        en;
        logic [2:0]  dest;
        logic [3:0]  t1;
        logic [31:0] d1;
        logic [3:0]  t2;
        logic [31:0] d2;
        logic [4:0]  op;
        logic [31:0] pc;
        logic        cav;
        logic [2:0]  cat;
        logic [31:0] cad;
        logic        clv;
        logic [2:0]  clt;
        logic [31:0] cld;
        logic        ev;
        logic [4:0]  eop;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  edest;
        logic [31:0] epc;
        logic        efull;
    } vec_t;

    vec_t vt [17];

    function automatic logic [79:0] pkt(input logic [2:0] dest, input logic [3:0] t2,
                                        input logic [31:0] d2, input logic [3:0] t1,
                                        input logic [31:0] d1, input logic [4:0] op);
        return {dest, t2, d2, t1, d1, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic ev, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [2:0] dest,
                           input logic [31:0] pc, input logic full);
        chk({name, ".exValid"}, 64'(exValid), 64'(ev));
        chk({name, ".rsFull"}, 64'(rsFull), 64'(full));
        if (ev) begin
            chk({name, ".exOp"}, 64'(exOp), 64'(op));
            chk({name, ".exA"}, 64'(exA), 64'(a));
            chk({name, ".exB"}, 64'(exB), 64'(b));
            chk({name, ".exDest"}, 64'(exDest), 64'(dest));
            chk({name, ".exPC"}, 64'(exPC), 64'(pc));
        end
    endtask

    task automatic idle_inputs();
        aluEnable = 1'b0; aluData = '0; inst_PC = '0; flush = 1'b0;
        cdbAluValid = 1'b0; cdbAluTag = '0; cdbAluData = '0;
        cdbLsValid = 1'b0; cdbLsTag = '0; cdbLsData = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [2:0] dest, input logic [3:0] t1, input logic [31:0] d1,
                         input logic [3:0] t2, input logic [31:0] d2, input logic [4:0] op,
                         input logic [31:0] pc);
        aluEnable = 1'b1;
        aluData   = pkt(dest, t2, d2, t1, d1, op);
        inst_PC   = pc;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        exReady = 1'b1;

        for (int i = 0; i < 17; i++) vt[i] = '{default: '0};
        // back-to-back ready ops
        vt[0]  = '{default: '0, en: 1'b1, dest: 3'd3, t1: FT, d1: 32'd5, t2: FT, d2: 32'd7, op: 5'd1, pc: 32'h100};
        vt[1]  = '{default: '0, en: 1'b1, dest: 3'd4, t1: FT, d1: 32'd20, t2: FT, d2: 32'd8, op: 5'd2, pc: 32'h104,
                   ev: 1'b1, eop: 5'd1, ea: 32'd5, eb: 32'd7, edest: 3'd3, epc: 32'h100};
        vt[2]  = '{default: '0, ev: 1'b1, eop: 5'd2, ea: 32'd20, eb: 32'd8, edest: 3'd4, epc: 32'h104};
        // load CDB wakes tag1 two cycles after allocation
        vt[4]  = '{default: '0, en: 1'b1, dest: 3'd5, t1: 4'b0010, t2: FT, d2: 32'd9, op: 5'd3, pc: 32'h200};
        vt[6]  = '{default: '0, clv: 1'b1, clt: 3'b010, cld: 32'hDEAD};
        vt[7]  = '{default: '0, ev: 1'b1, eop: 5'd3, ea: 32'hDEAD, eb: 32'd9, edest: 3'd5, epc: 32'h200};
        // broadcast coincident with allocation is captured
        vt[8]  = '{default: '0, en: 1'b1, dest: 3'd6, t1: 4'b0011, t2: FT, d2: 32'd11, op: 5'd4, pc: 32'h300,
                   cav: 1'b1, cat: 3'd3, cad: 32'hBEEF};
        vt[9]  = '{default: '0, ev: 1'b1, eop: 5'd4, ea: 32'hBEEF, eb: 32'd11, edest: 3'd6, epc: 32'h300};
        // both CDBs resolve different operands in one cycle
        vt[10] = '{default: '0, en: 1'b1, dest: 3'd7, t1: 4'b0101, t2: 4'b0110, op: 5'd5, pc: 32'h400};
        vt[11] = '{default: '0, cav: 1'b1, cat: 3'd5, cad: 32'h55, clv: 1'b1, clt: 3'd6, cld: 32'h66};
        vt[12] = '{default: '0, ev: 1'b1, eop: 5'd5, ea: 32'h55, eb: 32'h66, edest: 3'd7, epc: 32'h400};
        // same tag on both CDBs: ALU data wins
        vt[13] = '{default: '0, en: 1'b1, dest: 3'd1, t1: 4'b0101, t2: FT, d2: 32'd1, op: 5'd6, pc: 32'h500};
        vt[14] = '{default: '0, cav: 1'b1, cat: 3'd5, cad: 32'hA1, clv: 1'b1, clt: 3'd5, cld: 32'hB2};
        vt[15] = '{default: '0, ev: 1'b1, eop: 5'd6, ea: 32'hA1, eb: 32'd1, edest: 3'd1, epc: 32'h500};

        step();
        step();
        rst = 1'b0;
        chk("reset.rsFull", 64'(rsFull), 64'd0);
        chk("reset.exValid", 64'(exValid), 64'd0);
        chk("reset.exOp", 64'(exOp), 64'd0);
        chk("reset.exA", 64'(exA), 64'd0);
        chk("reset.exB", 64'(exB), 64'd0);
        chk("reset.exPC", 64'(exPC), 64'd0);
        chk("reset.exDest", 64'(exDest), 64'd0);

        for (int i = 0; i < 17; i++) begin
            aluEnable   = vt[i].en;
            aluData     = pkt(vt[i].dest, vt[i].t2, vt[i].d2, vt[i].t1, vt[i].d1, vt[i].op);
            inst_PC     = vt[i].pc;
            cdbAluValid = vt[i].cav; cdbAluTag = vt[i].cat; cdbAluData = vt[i].cad;
            cdbLsValid  = vt[i].clv; cdbLsTag  = vt[i].clt; cdbLsData  = vt[i].cld;
            step();
            chk_out($sformatf("vec%0d", i), vt[i].ev, vt[i].eop, vt[i].ea, vt[i].eb,
                    vt[i].edest, vt[i].epc, vt[i].efull);
        end
        idle_inputs();

        // fill all 8 entries with ops waiting on tag 7, exReady low
        exReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            alloc(3'(i), 4'b0111, 32'd0, FT, 32'(i), 5'(8 + i), 32'h1000 + 32'(4 * i));
            step();
            chk_out($sformatf("fill%0d", i), 1'b0, '0, '0, '0, '0, '0, (i == 7));
        end
        alloc(3'd7, FT, 32'hFF, FT, 32'hFF, 5'd31, 32'hFFF);
        step();
        chk_out("drop9th", 1'b0, '0, '0, '0, '0, '0, 1'b1);
        idle_inputs();
        cdbAluValid = 1'b1; cdbAluTag = 3'd7; cdbAluData = 32'h70;
        step();
        chk_out("wakeall", 1'b0, '0, '0, '0, '0, '0, 1'b1);
        idle_inputs();
        step();
        chk_out("first_issue", 1'b1, 5'd8, 32'h70, 32'd0, 3'd0, 32'h1000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("stall%0d", k), 1'b1, 5'd8, 32'h70, 32'd0, 3'd0, 32'h1000, 1'b0);
        end
        exReady = 1'b1;
        for (int j = 1; j < 8; j++) begin
            step();
            chk_out($sformatf("drain%0d", j), 1'b1, 5'(8 + j), 32'h70, 32'(j), 3'(j),
                    32'h1000 + 32'(4 * j), 1'b0);
        end
        step();
        chk_out("drained", 1'b0, '0, '0, '0, '0, '0, 1'b0);

        // flush with an allocation in the same cycle
        for (int pass = 0; pass < 2; pass++) begin
            exReady = 1'b0;
            for (int i = 0; i < 6; i++) begin
                alloc(3'(i), FT, 32'h10 + 32'(i), FT, 32'd0, 5'(16 + i), 32'h2000 + 32'(4 * i));
                step();
            end
            chk_out($sformatf("pre_clear%0d", pass), 1'b1, 5'd16, 32'h10, 32'd0, 3'd0, 32'h2000, 1'b0);
            alloc(3'd7, FT, 32'h99, FT, 32'h99, 5'd30, 32'h3000);
            exReady = 1'b1;
            if (pass == 0) flush = 1'b1;
            else rst = 1'b1;
            step();
            chk_out($sformatf("clear%0d", pass), 1'b0, '0, '0, '0, '0, '0, 1'b0);
            if (pass == 1) begin
                chk("rst.exOp", 64'(exOp), 64'd0);
                chk("rst.exA", 64'(exA), 64'd0);
                chk("rst.exPC", 64'(exPC), 64'd0);
                chk("rst.exDest", 64'(exDest), 64'd0);
            end
            idle_inputs();
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                chk_out($sformatf("post_clear%0d_%0d", pass, k), 1'b0, '0, '0, '0, '0, '0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
